arb_mux: RTL

Parametrised N-way multiplexer that replaces fixed 4-1 select muxes wherever several producers contend for one pipeline consumer (e.g. writeback source, memory-port sharing). It picks one channel per cycle, using one of three modes: external select, fixed priority, or round-robin. The chosen word goes into a single output register with a valid/ready handshake and a flush input. One clock domain. Sits between producer stages and the next pipeline register.

---
 rtl/arb_mux_pkg.sv | 14 +
 rtl/arb_mux_rr_arbiter.sv | 43 ++++
 rtl/arb_mux.sv | 110 +++++++++++
 3 files changed

// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arb_mux channel selector: selection mode encodings.
package arb_mux_pkg;

  localparam int MUX_MODE_SEL  = 0;
  localparam int MUX_MODE_PRIO = 1;
  localparam int MUX_MODE_RR   = 2;

  typedef enum logic [1:0] {
    MUX_SEL  = 2'd0,
    MUX_PRIO = 2'd1,
    MUX_RR   = 2'd2
  } mux_mode_e;

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational request arbiter: fixed priority from index 0, or rotating
// priority starting at i_ptr when i_mode is MUX_RR. Produces one-hot and index.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [SELW-1:0] i_ptr,
  input  mux_mode_e       i_mode,
  output logic [N-1:0]    o_grant,
  output logic [SELW-1:0] o_grant_idx
);

  localparam int              IDXW = SELW + 1;
  localparam logic [IDXW-1:0] N_L  = IDXW'(N);

  logic [SELW-1:0] w_start;
  logic [IDXW-1:0] w_idx;
  logic            w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    w_start     = (i_mode == MUX_RR) ? i_ptr : '0;
    // Walk start, start+1, ... modulo N; one extra index bit holds the unwrapped sum.
    for (int j = 0; j < N; j++) begin
      w_idx = {1'b0, w_start} + IDXW'(j);
      if (w_idx >= N_L) begin
        w_idx = w_idx - N_L;
      end
      if (!w_found && i_req[w_idx[SELW-1:0]]) begin
        w_found                     = 1'b1;
        o_grant[w_idx[SELW-1:0]]    = 1'b1;
        o_grant_idx                 = w_idx[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-way channel selector feeding one output register with valid/ready and flush.
// Mode chooses external select, fixed priority or round-robin arbitration.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int   WIDTH = 32,
  parameter int   N     = 4,
  parameter int   MODE  = MUX_MODE_SEL,
  localparam int  SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  input  logic                 out_ready
);

  localparam int        IDXW   = SELW + 1;
  localparam mux_mode_e MODE_E = (MODE == MUX_MODE_RR)   ? MUX_RR   :
                                 (MODE == MUX_MODE_PRIO) ? MUX_PRIO : MUX_SEL;

  function automatic logic [SELW-1:0] ptr_after(input logic [SELW-1:0] idx);
    if (idx == SELW'(N - 1)) begin
      return '0;
    end
    return idx + SELW'(1);
  endfunction

  logic                r_vld_p1;
  logic [WIDTH-1:0]    r_data_p1;
  logic [SELW-1:0]     r_src_p1;
  logic [SELW-1:0]     r_ptr;

  logic                w_sel_ok;
  logic [N-1:0]        w_req;
  logic [N-1:0]        w_grant;
  logic [SELW-1:0]     w_gidx;
  logic                w_any;
  logic                w_load;
  logic [WIDTH-1:0]    w_gdata;

  // Stage p0: request shaping, arbitration and load decision.
  assign w_sel_ok = ({1'b0, sel} < IDXW'(N));

  always_comb begin
    w_req = in_valid;
    if (MODE_E == MUX_SEL) begin
      w_req = '0;
      if (w_sel_ok) begin
        w_req[sel] = in_valid[sel];
      end
    end
  end

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .i_req       (w_req),
    .i_ptr       (r_ptr),
    .i_mode      (MODE_E),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );

  assign w_any    = |w_grant;
  assign w_load   = !rst && !flush && (!r_vld_p1 || out_ready);
  assign in_ready = w_grant & {N{w_load}};
  assign w_gdata  = in_data[w_gidx*WIDTH +: WIDTH];

  // Stage p1: output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_src_p1  <= '0;
      r_ptr     <= '0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_load) begin
      if (w_any) begin
        r_vld_p1  <= 1'b1;
        r_data_p1 <= w_gdata;
        r_src_p1  <= w_gidx;
        if (MODE_E == MUX_RR) begin
          r_ptr <= ptr_after(w_gidx);
        end
      end else begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_src   = r_src_p1;

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
    (r_vld_p1 && !out_ready) |=> ($stable(r_data_p1) && $stable(r_src_p1)));
`endif

endmodule
